// File: rtl/backing_memory_if.sv
// Request/completion bundle between the L1 cache (master) and the backing memory (slave).
interface backing_memory_if;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_type;
    logic        req_do;
    logic [31:0] O_data;
    logic        req_done;
    logic        req_err;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output req_addr, req_data, req_type, req_do,
        input  O_data, req_done, req_err, busy, rd_count, wr_count
    );

    modport slave (
        input  req_addr, req_data, req_type, req_do,
        output O_data, req_done, req_err, busy, rd_count, wr_count
    );
endinterface

// File: rtl/backing_memory.sv
// Fixed-latency word memory behind the L1: one outstanding request, single-cycle done pulse,
// saturating access counters and an out-of-range error flag.
module backing_memory #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic             clk,
    input  logic             reset,
    backing_memory_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [DEPTH_LOG2-1:0] idx;
        logic [31:0]           data;
        logic                  wr;
        logic                  oor;
    } req_t;

    // BUSY spends LATENCY-1 cycles: counter runs LATENCY-2 down to 0.
    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    req_t        cap, inc, acc;
    logic        accept, enter_done;
    logic [31:0] o_data_q;
    logic [15:0] rd_cnt, wr_cnt;
    logic [31:0] mem [2**DEPTH_LOG2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[1:0];

    always_comb begin
        inc.idx  = bus.req_addr[DEPTH_LOG2+1:2];
        inc.data = bus.req_data;
        inc.wr   = bus.req_type;
        inc.oor  = |bus.req_addr[31:DEPTH_LOG2+2];
    end

    // With LATENCY=1 the array is accessed on the accept edge, before cap is loaded.
    assign acc = (state == IDLE) ? inc : cap;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_do) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) cap <= inc;
        end
    end

    // Array has no reset so it maps onto block RAM; reset still blocks a pending write.
    always_ff @(posedge clk) begin
        if (reset && enter_done && acc.wr && !acc.oor)
            mem[acc.idx] <= acc.data;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            o_data_q <= 32'd0;
        else if (enter_done && !acc.wr && !acc.oor)
            o_data_q <= mem[acc.idx];
        else
            o_data_q <= 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (state == DONE) begin
            if (cap.wr && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
            else if (!cap.wr && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign bus.O_data   = o_data_q;
    assign bus.req_done = (state == DONE);
    assign bus.req_err  = (state == DONE) && cap.oor;
    assign bus.busy     = (state != IDLE);
    assign bus.rd_count = rd_cnt;
    assign bus.wr_count = wr_cnt;
endmodule

// File: tb/tb_backing_memory.sv
// Scoreboarded bench: LATENCY=4 and LATENCY=1 instances share clock and reset.
module tb_backing_memory;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    backing_memory_if b4();
    backing_memory_if b1();

    backing_memory #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    backing_memory #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every req_done pops one expectation; outside done O_data must be 0.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (b4.req_done === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4_unexpected_done: req_done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q4.pop_front();
                chk("dut4_done_cycle", cyc, e.due);
                chk("dut4_O_data", b4.O_data, e.data);
                chk("dut4_req_err", {31'd0, b4.req_err}, {31'd0, e.err});
                chk("dut4_busy_at_done", {31'd0, b4.busy}, 32'd1);
            end
        end else if (reset) begin
            chk("dut4_O_data_idle", b4.O_data, 32'd0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (b1.req_done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_done: req_done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1_done_cycle", cyc, e.due);
                chk("dut1_O_data", b1.O_data, e.data);
                chk("dut1_req_err", {31'd0, b1.req_err}, {31'd0, e.err});
            end
        end else if (reset) begin
            chk("dut1_O_data_idle", b1.O_data, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one request for a single cycle; returns at the negedge of the next cycle.
    task automatic issue(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_data, input bit exp_err, input bit expect_done);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            b1.req_do = 1'b1; b1.req_type = wr; b1.req_addr = addr; b1.req_data = data;
        end else begin
            b4.req_do = 1'b1; b4.req_type = wr; b4.req_addr = addr; b4.req_data = data;
        end
        if (expect_done) begin
            e.due = cyc + (sel ? 1 : 4); e.data = exp_data; e.err = exp_err;
            if (sel) q1.push_back(e); else q4.push_back(e);
        end
        @(negedge clk);
        if (sel) b1.req_do = 1'b0; else b4.req_do = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_O_data"},   b4.O_data, 32'd0);
        chk({tag, "_req_done"}, {31'd0, b4.req_done}, 32'd0);
        chk({tag, "_req_err"},  {31'd0, b4.req_err}, 32'd0);
        chk({tag, "_busy"},     {31'd0, b4.busy}, 32'd0);
        chk({tag, "_rd_count"}, {16'd0, b4.rd_count}, 32'd0);
        chk({tag, "_wr_count"}, {16'd0, b4.wr_count}, 32'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        b4.req_do = 0; b4.req_type = 0; b4.req_addr = 0; b4.req_data = 0;
        b1.req_do = 0; b1.req_type = 0; b1.req_addr = 0; b1.req_data = 0;
        reset = 1'b0;
        idle(3);
        chk_all_zero("reset");
        reset = 1'b1;

        // Write then read back through the LATENCY=4 instance.
        issue(0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0, 1);
        chk("busy_after_accept", {31'd0, b4.busy}, 32'd1);
        idle(3);
        issue(0, 0, 32'h10, 32'h0, 32'hCAFE_F00D, 0, 1);
        idle(4);
        chk("rd_count_1", {16'd0, b4.rd_count}, 32'd1);
        chk("wr_count_1", {16'd0, b4.wr_count}, 32'd1);
        chk("busy_idle", {31'd0, b4.busy}, 32'd0);

        // Strobes at T+1, T+2, T+4 of an outstanding read are ignored; T+5 is accepted.
        issue(0, 0, 32'h10, 32'h0, 32'hCAFE_F00D, 0, 1);
        b4.req_do = 1'b1; b4.req_type = 1'b1; b4.req_addr = 32'h10; b4.req_data = 32'hBAD0_BAD0;
        idle(1);
        idle(1);
        b4.req_do = 1'b0;
        chk("busy_mid_request", {31'd0, b4.busy}, 32'd1);
        idle(1);
        b4.req_do = 1'b1;
        issue(0, 0, 32'h10, 32'h0, 32'hCAFE_F00D, 0, 1);
        idle(4);
        chk("rd_count_after_ignore", {16'd0, b4.rd_count}, 32'd3);
        chk("wr_count_after_ignore", {16'd0, b4.wr_count}, 32'd1);

        // Out-of-range accesses: write dropped, read returns 0, req_err set.
        issue(0, 1, 32'h0, 32'h1234_5678, 32'h0, 0, 1);
        idle(3);
        issue(0, 1, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1, 1);
        idle(3);
        issue(0, 0, 32'h0, 32'h0, 32'h1234_5678, 0, 1);
        idle(3);
        issue(0, 0, 32'h0001_0000, 32'h0, 32'h0, 1, 1);
        idle(4);
        chk("rd_count_oor", {16'd0, b4.rd_count}, 32'd5);
        chk("wr_count_oor", {16'd0, b4.wr_count}, 32'd3);

        // Reset during a write drops it with no req_done.
        issue(0, 1, 32'h20, 32'h1111_1111, 32'h0, 0, 1);
        idle(3);
        issue(0, 1, 32'h20, 32'h2222_2222, 32'h0, 0, 0);
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk_all_zero("midreset");
        idle(5);
        issue(0, 0, 32'h20, 32'h0, 32'h1111_1111, 0, 1);
        idle(4);
        chk("rd_count_post_reset", {16'd0, b4.rd_count}, 32'd1);
        chk("wr_count_post_reset", {16'd0, b4.wr_count}, 32'd0);

        // LATENCY=1: back-to-back every 2 cycles, byte offsets alias the same word.
        issue(1, 1, 32'h3, 32'hA5A5_0003, 32'h0, 0, 1);
        issue(1, 0, 32'h0, 32'h0, 32'hA5A5_0003, 0, 1);
        issue(1, 1, 32'h4, 32'h0000_0044, 32'h0, 0, 1);
        issue(1, 0, 32'h7, 32'h0, 32'h0000_0044, 0, 1);
        idle(1);
        chk("lat1_rd_count", {16'd0, b1.rd_count}, 32'd2);
        chk("lat1_wr_count", {16'd0, b1.wr_count}, 32'd2);

        // Drive the write counter past 16'hFFFF (2 earlier writes + 65538 here).
        for (int i = 0; i < 65538; i++) begin
            issue(1, 1, 32'h8, i, 32'h0, 0, 1);
            if (i == 65531) begin
                idle(1);
                chk("wr_count_fffe", {16'd0, b1.wr_count}, 32'h0000_FFFE);
            end
        end
        idle(1);
        chk("wr_count_saturated", {16'd0, b1.wr_count}, 32'h0000_FFFF);
        chk("rd_count_unchanged", {16'd0, b1.rd_count}, 32'd2);
        issue(1, 0, 32'h8, 32'h0, 32'd65537, 0, 1);
        idle(3);
        chk("q4_drained", q4.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/backing_memory.md
Name: backing_memory

Overview:
- Word-organised main-memory model that sits directly downstream of the L1 cache and serves its miss reads and write-through writes.
- Accepts one single-cycle request strobe and returns a single-cycle completion pulse after a fixed, parameterised latency.
- No queueing: one outstanding request at a time.
- Keeps saturating read/write counters and flags out-of-range accesses for CW305 debug readout.

Parameters:
- DEPTH_LOG2, 10: memory holds 2**DEPTH_LOG2 32-bit words.
- LATENCY, 4: cycles from the accepted req_do cycle to the req_done cycle. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets.
- req_addr  in  32  byte address; word index = req_addr[DEPTH_LOG2+1:2]; req_addr[1:0] ignored.
- req_data  in  32  write data.
- req_type  in  1  0 = read, 1 = write.
- req_do  in  1  request strobe, sampled only in IDLE.
- O_data  out  32  read data, valid only while req_done=1 for a read, else 0.
- req_done  out  1  one-cycle completion pulse.
- req_err  out  1  high with req_done when the accessed address was out of range.
- busy  out  1  high from the cycle after acceptance through the req_done cycle.
- rd_count  out  16  completed reads, saturating at 16'hFFFF.
- wr_count  out  16  completed writes, saturating at 16'hFFFF.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, latency counter=0.
  - Captured address/data/type registers = 0.
  - O_data=0, req_done=0, req_err=0, busy=0, rd_count=0, wr_count=0.
  - Memory array is NOT cleared; power-up contents are all zero.
  - Reset wins over every other event, including reset mid-request: the in-flight request is dropped, no write is committed, and no req_done is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When req_do=1 at an edge, capture req_addr, req_data and req_type.
  - Out-of-range flag = (req_addr[31:DEPTH_LOG2+2] != 0).
  - LATENCY=1: go directly to DONE. Otherwise go to BUSY with counter=LATENCY-2.
- BUSY:
  - When counter==0, go to DONE; otherwise decrement.
  - req_do is ignored (not queued, not an error).
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - req_do during DONE is ignored. The next request is accepted in IDLE, earliest 1 cycle after req_done.
- Timing: a req_do accepted in cycle T gives req_done=1 in cycle T+LATENCY only.
- Array access occurs at the edge that enters DONE:
  - Write in range: mem[index] <= captured data.
  - Read in range: output register <= mem[index].
  - A read issued after a completed write to the same word returns the new data.
- Outputs in the DONE cycle:
  - O_data = read data for an in-range read; 0 for a write, for an out-of-range read, and in every non-DONE cycle.
  - Out-of-range access: write dropped, read returns 0, req_err=1 with req_done.
- Counters: increment at the edge leaving DONE, by captured type, also for out-of-range accesses. Each holds at 16'hFFFF.
- busy = (state != IDLE).
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

Test Plan:
- LATENCY=4: write 0x0000_0010 <- 0xCAFE_F00D with req_do at T, then read 0x0000_0010 -> write req_done at T+4 only (O_data=0); read req_done 4 cycles after its acceptance with O_data=0xCAFE_F00D; rd_count=1, wr_count=1.
- Pulse req_do again at T+1, T+2 and T+4 during an outstanding read -> ignored; exactly one req_done; next request accepted only from T+5.
- Read 0x0001_0000 with DEPTH_LOG2=10 -> req_done and req_err=1, O_data=0; a preceding write to that address leaves mem[0] unchanged.
- Assert reset=0 at T+2 of a write to 0x20 -> no req_done; all outputs 0 next cycle; a later read of 0x20 returns its prior value.
- LATENCY=1: back-to-back requests every 2 cycles -> req_done one cycle after each req_do; addresses 0x3 and 0x0 alias the same word.
- Force 65,540 writes -> wr_count saturates at 16'hFFFF and does not wrap.
